// File: rtl/frame_update_scheduler_if.sv
// Start/done handshake between the frame update scheduler and its object engines.
// The scheduler owns upd_start; each engine answers on its own upd_done bit.
interface frame_update_scheduler_if #(
  parameter int NUM_CLIENTS = 4
);
  logic [NUM_CLIENTS-1:0] upd_start;
  logic [NUM_CLIENTS-1:0] upd_done;

  modport master (output upd_start, input upd_done);
  modport slave  (input upd_start, output upd_done);
endinterface

// File: rtl/frame_update_scheduler.sv
// Grants per-frame update slots to object engines, one at a time, starting at each
// Vsync falling edge so game state only changes while the screen is blanked.
module frame_update_scheduler #(
  parameter int NUM_CLIENTS = 4,
  parameter int TIMEOUT     = 1024,
  parameter int FCNT_W      = 16
) (
  input  logic                            pixel_clock,
  input  logic                            rst_n,
  input  logic                            Vsync,
  input  logic                            pause,
  input  logic [3:0]                      frame_div,
  input  logic                            clr_err,
  frame_update_scheduler_if.master        upd,
  output logic                            busy,
  output logic [FCNT_W-1:0]               frame_cnt,
  output logic                            overrun,
  output logic                            timeout_err
);

  localparam int IDX_W = (NUM_CLIENTS > 1) ? $clog2(NUM_CLIENTS) : 1;
  localparam int WC_W  = $clog2(TIMEOUT);

  localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(NUM_CLIENTS - 1);
  localparam logic [IDX_W-1:0]  IDX_ONE   = IDX_W'(1);
  localparam logic [WC_W-1:0]   WAIT_LAST = WC_W'(TIMEOUT - 1);
  localparam logic [WC_W-1:0]   WC_ONE    = WC_W'(1);
  localparam logic [FCNT_W-1:0] FCNT_ONE  = FCNT_W'(1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_DONE
  } state_e;

  state_e                 state_q,       state_d;
  logic                   vsync_q,       vsync_d;
  logic [3:0]             div_cnt_q,     div_cnt_d;
  logic [IDX_W-1:0]       idx_q,         idx_d;
  logic [WC_W-1:0]        wait_cnt_q,    wait_cnt_d;
  logic [NUM_CLIENTS-1:0] upd_start_q,   upd_start_d;
  logic [FCNT_W-1:0]      frame_cnt_q,   frame_cnt_d;
  logic                   overrun_q,     overrun_d;
  logic                   timeout_err_q, timeout_err_d;

  logic       vs_fall;
  logic [3:0] div_last;
  logic       advance;
  logic       timeout_set;
  logic       overrun_set;

  always_comb begin
    // NOTE: every _d starts from its _q so no path through this block infers a latch.
    state_d       = state_q;
    div_cnt_d     = div_cnt_q;
    idx_d         = idx_q;
    wait_cnt_d    = wait_cnt_q;
    frame_cnt_d   = frame_cnt_q;
    vsync_d       = Vsync;
    advance       = 1'b0;
    timeout_set   = 1'b0;

    vs_fall     = vsync_q & ~Vsync;
    div_last    = (frame_div <= 4'd1) ? 4'd0 : (frame_div - 4'd1);
    // An edge that lands mid-sequence is flagged and otherwise dropped.
    overrun_set = vs_fall && (state_q != S_IDLE);

    case (state_q)
      S_IDLE: begin
        if (vs_fall && !pause) begin
          if (div_cnt_q == div_last) begin
            div_cnt_d = 4'd0;
            idx_d     = '0;
            state_d   = S_ISSUE;
          end else begin
            div_cnt_d = div_cnt_q + 4'd1;
          end
        end
      end

      S_ISSUE: begin
        wait_cnt_d = '0;
        state_d    = S_WAIT;
      end

      S_WAIT: begin
        if (upd.upd_done[idx_q]) begin
          advance = 1'b1;
        end else if (wait_cnt_q == WAIT_LAST) begin
          timeout_set = 1'b1;
          advance     = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q + WC_ONE;
        end

        if (advance) begin
          if (idx_q == LAST_IDX) begin
            state_d = S_DONE;
          end else begin
            idx_d   = idx_q + IDX_ONE;
            state_d = S_ISSUE;
          end
        end
      end

      S_DONE: begin
        frame_cnt_d = frame_cnt_q + FCNT_ONE;
        idx_d       = '0;
        state_d     = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase

    // Start pulse is registered alongside the ISSUE state so it lines up with it exactly.
    upd_start_d   = (state_d == S_ISSUE) ? (NUM_CLIENTS'(1) << idx_d) : '0;
    overrun_d     = overrun_set | (overrun_q & ~clr_err);
    timeout_err_d = timeout_set | (timeout_err_q & ~clr_err);
  end

  always_ff @(posedge pixel_clock or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      vsync_q       <= 1'b1;
      div_cnt_q     <= 4'd0;
      idx_q         <= '0;
      wait_cnt_q    <= '0;
      upd_start_q   <= '0;
      frame_cnt_q   <= '0;
      overrun_q     <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the same pre-edge values.
      state_q       <= state_d;
      vsync_q       <= vsync_d;
      div_cnt_q     <= div_cnt_d;
      idx_q         <= idx_d;
      wait_cnt_q    <= wait_cnt_d;
      upd_start_q   <= upd_start_d;
      frame_cnt_q   <= frame_cnt_d;
      overrun_q     <= overrun_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign upd.upd_start = upd_start_q;
  assign busy          = (state_q != S_IDLE);
  assign frame_cnt     = frame_cnt_q;
  assign overrun       = overrun_q;
  assign timeout_err   = timeout_err_q;

endmodule

// File: tb/tb_frame_update_scheduler.sv
// Directed bench for frame_update_scheduler: divider, handshake order, timeout,
// overrun, pause and async reset, with a narrow frame counter to exercise wrap.
module tb_frame_update_scheduler;

  localparam int NC = 4;
  localparam int TO = 16;
  localparam int FW = 3;

  logic          pixel_clock = 1'b0;
  logic          rst_n       = 1'b0;
  logic          Vsync       = 1'b1;
  logic          pause       = 1'b0;
  logic          clr_err     = 1'b0;
  logic [3:0]    frame_div   = 4'd1;
  logic          busy;
  logic [FW-1:0] frame_cnt;
  logic          overrun;
  logic          timeout_err;

  frame_update_scheduler_if #(.NUM_CLIENTS(NC)) bus ();

  frame_update_scheduler #(
    .NUM_CLIENTS (NC),
    .TIMEOUT     (TO),
    .FCNT_W      (FW)
  ) dut (
    .pixel_clock (pixel_clock),
    .rst_n       (rst_n),
    .Vsync       (Vsync),
    .pause       (pause),
    .frame_div   (frame_div),
    .clr_err     (clr_err),
    .upd         (bus.master),
    .busy        (busy),
    .frame_cnt   (frame_cnt),
    .overrun     (overrun),
    .timeout_err (timeout_err)
  );

  always #5 pixel_clock = ~pixel_clock;

  int            cyc   = 0;
  int            n_vec = 0;
  int            n_err = 0;
  int            fall_cyc;
  int            p_cyc[$];
  logic [NC-1:0] p_val[$];
  int            done_dly[NC];
  int            since[NC];
  bit            armed[NC];
  logic [FW-1:0] exp_fcnt;

  always @(posedge pixel_clock) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Client model: raises done for one cycle, done_dly cycles after seeing its start.
  always @(negedge pixel_clock) begin
    for (int i = 0; i < NC; i++) begin
      if (bus.upd_start[i]) begin
        armed[i] = 1'b1;
        since[i] = 0;
      end else if (armed[i]) begin
        since[i]++;
      end
      if (armed[i] && done_dly[i] >= 0 && since[i] > done_dly[i]) armed[i] = 1'b0;
      bus.upd_done[i] = armed[i] && (since[i] == done_dly[i]);
    end
  end

  // Start-pulse log plus invariants that hold on every pulse.
  always @(negedge pixel_clock) begin
    if (bus.upd_start != '0) begin
      check("onehot", 32'($countones(bus.upd_start)), 1);
      check("start_while_busy", 32'(busy), 1);
      p_val.push_back(bus.upd_start);
      p_cyc.push_back(cyc);
    end
  end

  task automatic clear_log();
    p_val.delete();
    p_cyc.delete();
  endtask

  task automatic pulse_vsync();
    @(negedge pixel_clock);
    Vsync    = 1'b0;
    fall_cyc = cyc;
    repeat (4) @(negedge pixel_clock);
    Vsync = 1'b1;
  endtask

  task automatic pulse_clr();
    @(negedge pixel_clock);
    clr_err = 1'b1;
    @(negedge pixel_clock);
    clr_err = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int k = 0;
    while (busy && k < 300) begin
      @(negedge pixel_clock);
      k++;
    end
    check({tag, ".idle"}, 32'(busy), 0);
  endtask

  task automatic wait_pulse(input string tag, input logic [NC-1:0] mask);
    int k = 0;
    while (bus.upd_start !== mask && k < 100) begin
      @(negedge pixel_clock);
      k++;
    end
    check({tag, ".pulse"}, 32'(bus.upd_start), 32'(mask));
  endtask

  // One complete sequence in the log: clients 0..3 in order, starting right after the fall.
  task automatic check_seq(input string tag);
    check({tag, ".npulse"}, 32'(p_val.size()), 4);
    if (p_val.size() >= 4) begin
      for (int i = 0; i < 4; i++)
        check($sformatf("%s.order%0d", tag, i), 32'(p_val[i]), 32'(1 << i));
      check({tag, ".latency"}, 32'(p_cyc[0] - fall_cyc), 1);
    end
  endtask

  initial begin
    for (int i = 0; i < NC; i++) done_dly[i] = 3;
    exp_fcnt = '0;

    // Reset state
    repeat (3) @(negedge pixel_clock);
    check("rst.start", 32'(bus.upd_start), 0);
    check("rst.busy", 32'(busy), 0);
    check("rst.fcnt", 32'(frame_cnt), 0);
    check("rst.overrun", 32'(overrun), 0);
    check("rst.timeout", 32'(timeout_err), 0);
    rst_n = 1'b1;
    repeat (2) @(negedge pixel_clock);

    // 1: basic sequence, done 3 cycles after each start
    clear_log();
    pulse_vsync();
    wait_idle("t1");
    exp_fcnt++;
    check_seq("t1");
    for (int i = 0; i < 3; i++)
      check($sformatf("t1.gap%0d", i), 32'(p_cyc[i+1] - p_cyc[i]), 4);
    check("t1.fcnt", 32'(frame_cnt), 32'(exp_fcnt));
    check("t1.overrun", 32'(overrun), 0);
    check("t1.timeout", 32'(timeout_err), 0);

    // 2: divide by 3 over six falls, then frame_div=0 means every frame
    frame_div = 4'd3;
    clear_log();
    for (int f = 1; f <= 6; f++) begin
      pulse_vsync();
      repeat (30) @(negedge pixel_clock);
      if (f % 3 == 0) begin
        exp_fcnt++;
        check($sformatf("t2.latency%0d", f), 32'(p_cyc[(f == 3) ? 0 : 4] - fall_cyc), 1);
      end
      check($sformatf("t2.fcnt%0d", f), 32'(frame_cnt), 32'(exp_fcnt));
      check($sformatf("t2.npulse%0d", f), 32'(p_val.size()), (f >= 6) ? 8 : (f >= 3) ? 4 : 0);
    end
    frame_div = 4'd0;
    for (int f = 1; f <= 2; f++) begin
      clear_log();
      pulse_vsync();
      wait_idle($sformatf("t2z%0d", f));
      exp_fcnt++;
      check_seq($sformatf("t2z%0d", f));
      check($sformatf("t2z.fcnt%0d", f), 32'(frame_cnt), 32'(exp_fcnt));
    end

    // 3: client 2 only answers during ISSUE, which must be ignored, so it times out
    done_dly[2] = 0;
    clear_log();
    pulse_vsync();
    wait_idle("t3");
    exp_fcnt++;
    check_seq("t3");
    check("t3.gap12", 32'(p_cyc[2] - p_cyc[1]), 4);
    check("t3.gap23", 32'(p_cyc[3] - p_cyc[2]), TO + 1);
    check("t3.timeout", 32'(timeout_err), 1);
    check("t3.overrun", 32'(overrun), 0);
    check("t3.fcnt", 32'(frame_cnt), 32'(exp_fcnt));
    done_dly[2] = 3;
    pulse_clr();
    check("t3.clr", 32'(timeout_err), 0);

    // 4: fall while busy sets overrun without a second sequence
    clear_log();
    pulse_vsync();
    repeat (4) @(negedge pixel_clock);
    pulse_vsync();
    check("t4.overrun", 32'(overrun), 1);
    wait_idle("t4a");
    exp_fcnt++;
    check("t4a.npulse", 32'(p_val.size()), 4);
    check("t4a.fcnt", 32'(frame_cnt), 32'(exp_fcnt));
    pulse_clr();
    check("t4.clr", 32'(overrun), 0);
    // set and clear in the same cycle: set wins; this sequence also wraps frame_cnt
    clear_log();
    pulse_vsync();
    repeat (4) @(negedge pixel_clock);
    @(negedge pixel_clock);
    Vsync   = 1'b0;
    clr_err = 1'b1;
    @(negedge pixel_clock);
    clr_err = 1'b0;
    repeat (3) @(negedge pixel_clock);
    Vsync = 1'b1;
    check("t4.setwins", 32'(overrun), 1);
    wait_idle("t4b");
    exp_fcnt++;
    check("t4b.npulse", 32'(p_val.size()), 4);
    check("t4b.wrap", 32'(frame_cnt), 0);
    pulse_clr();

    // 5: pause mid-sequence finishes it; paused falls leave div_cnt alone
    frame_div = 4'd3;
    clear_log();
    for (int f = 1; f <= 2; f++) begin
      pulse_vsync();
      repeat (10) @(negedge pixel_clock);
    end
    check("t5.nofire", 32'(p_val.size()), 0);
    pulse_vsync();
    wait_pulse("t5.c1", 4'b0010);
    pause = 1'b1;
    wait_idle("t5");
    exp_fcnt++;
    check_seq("t5");
    check("t5.fcnt", 32'(frame_cnt), 32'(exp_fcnt));
    clear_log();
    for (int f = 1; f <= 2; f++) begin
      pulse_vsync();
      repeat (10) @(negedge pixel_clock);
      check($sformatf("t5.pbusy%0d", f), 32'(busy), 0);
    end
    check("t5.paused", 32'(p_val.size()), 0);
    pause = 1'b0;
    pulse_vsync();
    repeat (30) @(negedge pixel_clock);
    check("t5.held", 32'(p_val.size()), 0);
    check("t5.fcnt2", 32'(frame_cnt), 32'(exp_fcnt));

    // 6: async reset while waiting on client 1
    frame_div = 4'd2;
    clear_log();
    pulse_vsync();
    wait_pulse("t6.c1", 4'b0010);
    @(negedge pixel_clock);
    #2 rst_n = 1'b0;
    #1;
    check("t6.start", 32'(bus.upd_start), 0);
    check("t6.busy", 32'(busy), 0);
    check("t6.fcnt", 32'(frame_cnt), 0);
    check("t6.overrun", 32'(overrun), 0);
    check("t6.timeout", 32'(timeout_err), 0);
    clear_log();
    repeat (5) @(negedge pixel_clock);
    rst_n = 1'b1;
    repeat (5) @(negedge pixel_clock);
    check("t6.quiet", 32'(p_val.size()), 0);
    frame_div = 4'd1;
    exp_fcnt  = '0;
    pulse_vsync();
    wait_idle("t6");
    exp_fcnt++;
    check_seq("t6");
    check("t6.fcnt2", 32'(frame_cnt), 32'(exp_fcnt));

    repeat (2) @(negedge pixel_clock);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
